// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the iterative MIPS EX-stage ALU.
package alu_pkg;

   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] OP_AND   = 4'b0000;
   localparam logic [OP_W-1:0] OP_OR    = 4'b0001;
   localparam logic [OP_W-1:0] OP_ADD   = 4'b0010;
   localparam logic [OP_W-1:0] OP_XOR   = 4'b0011;
   localparam logic [OP_W-1:0] OP_MULTU = 4'b0100;
   localparam logic [OP_W-1:0] OP_DIVU  = 4'b0101;
   localparam logic [OP_W-1:0] OP_SUB   = 4'b0110;
   localparam logic [OP_W-1:0] OP_SLT   = 4'b0111;
   localparam logic [OP_W-1:0] OP_SLL   = 4'b1000;
   localparam logic [OP_W-1:0] OP_SRL   = 4'b1001;
   localparam logic [OP_W-1:0] OP_SRA   = 4'b1010;
   localparam logic [OP_W-1:0] OP_NOR   = 4'b1100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// The first step is taken on the start edge, so done_o is high in the WIDTH-th cycle.
module alu_muldiv_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             op_div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic [WIDTH-1:0] hi_q, lo_q, b_q;
   logic [WIDTH-1:0] hi_d, lo_d;
   logic [WIDTH-1:0] cur_hi, cur_lo, cur_b;
   logic             cur_div;
   logic             div_q, busy_q, done_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH:0]   sum, rs, diff;

   // One iteration; on start it works straight from the incoming operands.
   always_comb begin
      cur_hi  = start_i ? '0 : hi_q;
      cur_lo  = start_i ? a_i : lo_q;
      cur_b   = start_i ? b_i : b_q;
      cur_div = start_i ? op_div_i : div_q;
      hi_d    = cur_hi;
      lo_d    = cur_lo;
      sum     = '0;
      rs      = '0;
      diff    = '0;
      if (cur_div) begin
         rs   = {cur_hi, cur_lo[WIDTH-1]};
         diff = rs - {1'b0, cur_b};
         if (!diff[WIDTH]) begin
            hi_d = diff[WIDTH-1:0];
            lo_d = {cur_lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_d = rs[WIDTH-1:0];
            lo_d = {cur_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         sum  = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_b} : '0);
         hi_d = sum[WIDTH:1];
         lo_d = {sum[0], cur_lo[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q   <= '0;
         lo_q   <= '0;
         b_q    <= '0;
         div_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            b_q    <= b_i;
            div_q  <= op_div_i;
            cnt_q  <= '0;
            busy_q <= 1'b1;
         end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 2)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: rtl/alu_iter.sv
// Registered MIPS EX-stage ALU: single-cycle logic/arith/shift/compare ops,
// iterative MULTU/DIVU into HI/LO, valid/ready on both sides.
module alu_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [3:0]       operation,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUResult,
   output logic [WIDTH-1:0] HI,
   output logic             Zero,
   output logic             div_zero,
   output logic             illegal
);

   localparam int unsigned SHW = $clog2(WIDTH);

   state_e           state_q;
   logic             in_ready_q, out_valid_q;
   logic [WIDTH-1:0] result_q, hi_q;
   logic             zero_q, div_zero_q, illegal_q;

   logic [WIDTH-1:0] alu_c;
   logic             illegal_c;
   logic [SHW-1:0]   shamt;
   logic             is_md, div0, md_start, md_done;
   logic [WIDTH-1:0] md_hi, md_lo;

   assign shamt    = SrcB[SHW-1:0];
   assign is_md    = (operation == OP_MULTU) || (operation == OP_DIVU);
   assign div0     = (operation == OP_DIVU) && (SrcB == '0);
   assign md_start = (state_q == S_IDLE) && in_valid && is_md && !div0;

   always_comb begin
      alu_c     = '0;
      illegal_c = 1'b0;
      case (operation)
         OP_ADD:   alu_c = SrcA + SrcB;
         OP_SUB:   alu_c = SrcA - SrcB;
         OP_AND:   alu_c = SrcA & SrcB;
         OP_OR:    alu_c = SrcA | SrcB;
         OP_NOR:   alu_c = ~(SrcA | SrcB);
         OP_XOR:   alu_c = SrcA ^ SrcB;
         OP_SLT:   alu_c = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         OP_SLL:   alu_c = SrcA << shamt;
         OP_SRL:   alu_c = SrcA >> shamt;
         OP_SRA:   alu_c = WIDTH'($signed(SrcA) >>> shamt);
         OP_MULTU: alu_c = '0;
         OP_DIVU:  alu_c = '0;
         default:  illegal_c = 1'b1;
      endcase
   end

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (md_start),
      .op_div_i (operation == OP_DIVU),
      .a_i      (SrcA),
      .b_i      (SrcB),
      .done_o   (md_done),
      .hi_o     (md_hi),
      .lo_o     (md_lo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         hi_q        <= '0;
         zero_q      <= 1'b0;
         div_zero_q  <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  in_ready_q <= 1'b0;
                  zero_q     <= 1'b0;
                  div_zero_q <= 1'b0;
                  illegal_q  <= 1'b0;
                  if (is_md && !div0) begin
                     state_q <= S_BUSY;
                  end else begin
                     state_q     <= S_DONE;
                     out_valid_q <= 1'b1;
                     if (div0) begin
                        result_q   <= '1;
                        hi_q       <= SrcA;
                        div_zero_q <= 1'b1;
                     end else begin
                        result_q  <= alu_c;
                        hi_q      <= '0;
                        zero_q    <= (alu_c == '0);
                        illegal_q <= illegal_c;
                     end
                  end
               end
            end
            S_BUSY: begin
               if (md_done) begin
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
                  result_q    <= md_lo;
                  hi_q        <= md_hi;
                  zero_q      <= (md_lo == '0);
               end
            end
            S_DONE: begin
               // Returning through IDLE leaves a one-cycle bubble before the next accept.
               if (out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign ALUResult = result_q;
   assign HI        = hi_q;
   assign Zero      = zero_q;
   assign div_zero  = div_zero_q;
   assign illegal   = illegal_q;

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
Parametrised, registered successor to the single-cycle datapath ALU for the MIPS core. It executes logic, arithmetic, shift and compare ops in one cycle, and unsigned MULTU/DIVU iteratively over WIDTH cycles into HI/LO. A valid/ready handshake lets the EX stage stall on long ops. It sits between the ID/EX register and the EX/MEM register.

Parameters:
WIDTH, 32, operand/result width in bits (power of two, >= 8).
SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operands and operation presented.
in_ready  out  1  block accepts a new operation this cycle.
SrcA  in  WIDTH  operand A.
SrcB  in  WIDTH  operand B; SrcB[SHW-1:0] is the shift amount.
operation  in  4  op code (see Behaviour).
out_valid  out  1  result registers hold a completed result.
out_ready  in  1  consumer takes the result this cycle.
ALUResult  out  WIDTH  primary result (LO for MULTU/DIVU).
HI  out  WIDTH  upper product / remainder; 0 for single-cycle ops.
Zero  out  1  ALUResult == 0.
div_zero  out  1  DIVU issued with SrcB == 0.
illegal  out  1  unknown op code.

Behaviour:
- Op codes: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 1100 NOR, 0011 XOR, 0111 SLT, 1000 SLL, 1001 SRL, 1010 SRA, 0100 MULTU, 0101 DIVU. All other codes are illegal.
- SLT: signed A < B gives 1, else 0, zero-extended.
- ADD/SUB: modulo 2^WIDTH; no overflow flag.
- SRA: arithmetic shift, replicating SrcA[WIDTH-1].
- States: IDLE, BUSY, DONE.
- in_ready = (state == IDLE). A transfer occurs when in_valid && in_ready.
- Single-cycle op or illegal code in IDLE: result, flags and HI register at the edge; go to DONE; out_valid = 1 the next cycle (latency 1).
- MULTU/DIVU in IDLE: latch operands, clear the counter, go to BUSY.
- MULTU in BUSY: shift-add, one bit per cycle.
- DIVU in BUSY: restoring division, one quotient bit per cycle.
- BUSY lasts exactly WIDTH cycles, then the FSM goes to DONE. out_valid rises WIDTH+1 cycles after acceptance.
- MULTU result: {HI, ALUResult} = full 2*WIDTH product.
- DIVU result: ALUResult = quotient, HI = remainder.
- DIVU with SrcB == 0: skip BUSY and go directly to DONE. ALUResult = all ones, HI = SrcA, div_zero = 1.
- Illegal op: ALUResult = 0, HI = 0, illegal = 1, Zero = 1.
- DONE: outputs held stable while out_valid && !out_ready. On out_ready, return to IDLE and drop out_valid. No new op is accepted in the same cycle (one bubble).
- Flags (Zero, div_zero, illegal) update only when a result is written. They clear when the next op is accepted.
- in_valid, SrcA, SrcB and operation are ignored in BUSY and DONE. Operand changes after acceptance have no effect.
- Reset (any time, including mid-BUSY): state = IDLE, in_ready = 1, out_valid = 0, ALUResult = 0, HI = 0, Zero = 0, div_zero = 0, illegal = 0, counter = 0. The partial product or quotient is discarded.

Decomposition:
- Package alu_pkg: op-code localparams (OP_ADD ... OP_DIVU), state enum (S_IDLE, S_BUSY, S_DONE).
- One sub-module, alu_muldiv_iter: takes start, a, b and op; returns done, hi and lo. It owns the counter and the shift/accumulate registers.
- The top level holds the combinational single-cycle ops, the FSM and the output registers.

Test Plan:
- Reset then ADD with WIDTH=32, A=7, B=5, out_ready=1 -> out_valid one cycle later, ALUResult=12, HI=0, Zero=0, then in_ready=1 again.
- SLT with A=0xFFFFFFFF (-1), B=1 -> ALUResult=1. SRA with A=0x80000000, B=4 -> ALUResult=0xF8000000.
- MULTU with A=0xFFFFFFFF, B=2 -> out_valid exactly 33 cycles after acceptance, HI=1, ALUResult=0xFFFFFFFE. in_ready=0 throughout.
- DIVU with A=100, B=7 -> ALUResult=14, HI=2 after 33 cycles. DIVU with B=0 -> next cycle ALUResult=0xFFFFFFFF, HI=100, div_zero=1.
- Backpressure: SUB with A=B=9, out_ready=0 for 5 cycles -> outputs held with ALUResult=0 and Zero=1. Op code 1111 -> illegal=1.
- Assert rst_n=0 at BUSY cycle 10 of a MULTU -> all outputs 0 and in_ready=1 immediately. A following ADD with A=1, B=1 -> ALUResult=2.
